// File: rtl/fft_frame_loader_if.sv
// ---------------------------------------------------------------------------
// fft_frame_loader_if
//   Bundles the sample-stream handshake and the parallel FFT-side frame bus
//   used by fft_frame_loader.
//
//   Stream side : in_valid / in_ready / in_real / in_imag / in_last
//   FFT side    : fft_start, fft_x_real[0:N_PTS-1], fft_x_imag[0:N_PTS-1],
//                 fft_done
//
//   modport slave  : the loader (consumes the stream, drives the FFT bus)
//   modport master : the environment (produces the stream, models the FFT)
// ---------------------------------------------------------------------------
interface fft_frame_loader_if #(
  parameter int DATA_W = 8,
  parameter int N_PTS  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     in_last;

  logic                     fft_start;
  logic signed [DATA_W-1:0] fft_x_real [0:N_PTS-1];
  logic signed [DATA_W-1:0] fft_x_imag [0:N_PTS-1];
  logic                     fft_done;

  modport slave (
    input  in_valid, in_real, in_imag, in_last, fft_done,
    output in_ready, fft_start, fft_x_real, fft_x_imag
  );

  modport master (
    output in_valid, in_real, in_imag, in_last, fft_done,
    input  in_ready, fft_start, fft_x_real, fft_x_imag
  );
endinterface

// File: rtl/fft_frame_loader.sv
// ---------------------------------------------------------------------------
// fft_frame_loader
//   Assembles a serial stream of complex samples into N_PTS-sample frames in
//   two ping-pong banks and hands each complete frame to the FFT core in
//   parallel. One bank fills while the other is being transformed.
//
// Ports
//   clk              : clock
//   rst_n            : asynchronous active-low reset
//   bus (slave)      : stream handshake in, parallel frame + start/done out
//   i_err_clr        : clears the sticky short-frame flag
//   o_frame_err      : sticky flag, set when in_last ends a frame early
//   o_frames_issued  : frames completed by the FFT (wraps at 16 bits)
// ---------------------------------------------------------------------------
module fft_frame_loader #(
  parameter int DATA_W = 8,
  parameter int N_PTS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_frame_loader_if.slave     bus,
  input  logic                  i_err_clr,
  output logic                  o_frame_err,
  output logic [15:0]           o_frames_issued
);

  localparam int                IDX_W    = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_PTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  // Write-side control
  logic              r_wb;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_full;
  logic              r_frame_err;

  // Read-side control
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rb;
  logic [15:0]       r_frames_issued;

  // Ping-pong sample storage (data only, never reset)
  logic signed [DATA_W-1:0] r_bank_re [0:1][0:N_PTS-1];
  logic signed [DATA_W-1:0] r_bank_im [0:1][0:N_PTS-1];

  logic              w_in_ready;
  logic              w_accept;
  logic              w_frame_end;
  logic              w_short;
  logic              w_release;
  logic              w_start;
  logic              w_rd_vis;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;

  assign w_in_ready  = !r_full[r_wb];
  assign w_accept    = bus.in_valid && w_in_ready;
  // in_last on the final index is a normal completion, not a short frame.
  assign w_frame_end = w_accept && (r_idx == LAST_IDX);
  assign w_short     = w_accept && bus.in_last && (r_idx != LAST_IDX);

  // Fill and release always hit different banks, so both masks can apply
  // on the same edge.
  assign w_full_set  = w_frame_end ? (2'b01 << r_wb) : 2'b00;
  assign w_full_clr  = w_release   ? (2'b01 << r_rb) : 2'b00;

  // --- write side: bank pointer, sample index, full flags, error flag ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb        <= 1'b0;
      r_idx       <= '0;
      r_full      <= 2'b00;
      r_frame_err <= 1'b0;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
      if (w_accept) begin
        if (w_frame_end || w_short) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_frame_end) begin
        r_wb <= ~r_wb;
      end
      // Setting takes priority over clearing.
      if (w_short) begin
        r_frame_err <= 1'b1;
      end else if (i_err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  // --- sample storage: written verbatim at the current write slot ---
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bank_re[r_wb][r_idx] <= bus.in_real;
      r_bank_im[r_wb][r_idx] <= bus.in_imag;
    end
  end

  // --- read side: issue FSM state, read pointer, issued-frame counter ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_rb            <= 1'b0;
      r_frames_issued <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_release) begin
        r_rb            <= ~r_rb;
        r_frames_issued <= r_frames_issued + 16'd1;
      end
    end
  end

  // Done is only honoured in S_WAIT; a pulse in S_IDLE or S_START is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rb]) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fft_done) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The frame bus shows bank[rb] while that bank holds a complete frame,
  // which covers the whole S_START..S_WAIT window; otherwise it reads zero,
  // so after reset the bus is clean without clearing the storage itself.
  assign w_rd_vis = r_full[r_rb];

  always_comb begin
    for (int i = 0; i < N_PTS; i++) begin
      bus.fft_x_real[i] = w_rd_vis ? r_bank_re[r_rb][i] : '0;
      bus.fft_x_imag[i] = w_rd_vis ? r_bank_im[r_rb][i] : '0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.fft_start    = w_start;
  assign o_frame_err      = r_frame_err;
  assign o_frames_issued  = r_frames_issued;

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Upstream feeder for the 8-point `fft` core. It accepts a serial stream of complex Q1.7 samples over a valid/ready handshake and assembles them into frames in two ping-pong banks. For each complete frame it presents the frame in parallel on `fft_x_real`/`fft_x_imag`, issues a one-cycle `fft_start`, and holds the frame stable until `fft_done`. While one bank is being transformed, the other bank fills.

## Interface
- `DATA_W`, 8: sample component width, signed two's complement (Q1.7).
- `N_PTS`, 8: samples per frame. Must be a power of two and must equal the FFT size.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: input sample valid.
- `in_ready`  out  1: loader can accept a sample.
- `in_real`  in  DATA_W: sample real part.
- `in_imag`  in  DATA_W: sample imaginary part.
- `in_last`  in  1: final sample of a frame. Only meaningful with `in_valid`.
- `fft_start`  out  1: one-cycle start pulse to the FFT.
- `fft_x_real`  out  DATA_W × [0:N_PTS-1]: frame real parts in natural order; index 0 is the first sample received.
- `fft_x_imag`  out  DATA_W × [0:N_PTS-1]: frame imaginary parts in natural order.
- `fft_done`  in  1: FFT completion pulse.
- `frame_err`  out  1: sticky flag for a short frame.
- `err_clr`  in  1: clears `frame_err`.
- `frames_issued`  out  16: count of frames completed by the FFT. Wraps at 0xFFFF → 0.

## Operation
- **Storage:** two banks, each holding N_PTS complex samples.
- **Write-side state:** write-bank pointer `wb`, sample index `idx` (log2 N_PTS bits), and `full[1:0]`.
- **Read-side state:** read-bank pointer `rb`.
- **Input acceptance:** `in_ready = !full[wb]`. A sample is accepted on a clock edge where `in_valid && in_ready`; it is written to `bank[wb][idx]`.
- **Normal frame completion:** when the accepted sample has `idx == N_PTS-1`:
  - set `full[wb]`, toggle `wb`, and set `idx` to 0;
  - `in_last` is ignored at this index.
- **Short frame:** when the accepted sample has `in_last` set and `idx < N_PTS-1`:
  - discard the partial frame and set `idx` to 0;
  - `full` is unchanged and `frame_err` is set to 1.
- **Otherwise:** `idx` increments.
- **Issue FSM:**
  - `S_IDLE`: when `full[rb]` is set, go to `S_START`.
  - `S_START`: go to `S_WAIT`.
  - `S_WAIT`: when `fft_done` is high, clear `full[rb]`, toggle `rb`, increment `frames_issued`, and go to `S_IDLE`.
- **Start pulse:** `fft_start` is a Moore output, high only in `S_START`.
- **Frame outputs:** `fft_x_real`/`fft_x_imag` come from `bank[rb]`. Contents are guaranteed stable from entry to `S_START` until the `S_WAIT` exit edge.
- **Spurious done:** `fft_done` is ignored in `S_IDLE` and `S_START`.
- **Simultaneous events:** write-side completion and read-side release in the same cycle always target different banks. Both updates take effect on that edge.
- **Error flag priority:** if `err_clr` and a short-frame event occur in the same cycle, the set wins and `frame_err` stays 1.
- **Datapath:** samples are stored verbatim, with no arithmetic, scaling or reordering. Bit reversal is done inside the FFT.

## Timing
- **Reset values:**
  - `in_ready`=1, `fft_start`=0, all `fft_x_*` = 0, `frame_err`=0, `frames_issued`=0;
  - FSM in `S_IDLE`, `wb`=`rb`=0, `idx`=0, `full`=0.
- **Reset mid-operation:** at any point, reset discards all banks and any in-flight frame immediately (asynchronously). No `fft_start` is issued until a new full frame arrives. The FFT shares `rst_n`.
- **Start latency:** the N_PTS-th sample is accepted at edge E. `fft_start` is high for exactly the cycle between edges E+1 and E+2.
- **Release latency:** `fft_done` is sampled high at edge D in `S_WAIT`. The freed bank accepts data from the cycle after D.
- **Next start:** if the other bank is already full, the next `fft_start` occurs between edges D+1 and D+2. The minimum issue period is FFT latency + 3 cycles.
- **Back-pressure:** `in_ready` drops in the cycle after the edge that fills the second bank. This is the only back-pressure condition.
- **Throughput:** continuous 1 sample/clk input sustains no stall when FFT latency + 3 ≤ N_PTS.

## Test plan
- **Reset:** assert and release `rst_n`, with no input → every output holds its reset value for 20 cycles and `fft_start` never pulses.
- **Single frame:** stream real 00,5A,7F,5A,00,A6,80,A6 with imag 0, `in_valid` constant →
  - `fft_start` pulses one cycle, one cycle after the 8th handshake;
  - `fft_x_real[0..7]` match the stream order and hold until `fft_done`;
  - `frames_issued`=1.
- **Back-pressure:** 24 back-to-back samples, with the FFT model returning `fft_done` 20 cycles after each start →
  - `in_ready`=0 after the 16th sample;
  - `in_ready` reasserts the cycle after the first `fft_done`;
  - three frames are issued in order; `frames_issued`=3.
- **Short frame:** `in_last` on the 3rd sample, then 8 samples 01..08 →
  - `frame_err`=1;
  - the issued frame is exactly 01..08;
  - `err_clr` returns `frame_err` to 0.
- **Reset mid-wait:** assert `rst_n` low during `S_WAIT` with the second bank full → after release there is no `fft_start` and `in_ready`=1.
- **Spurious done:** pulse `fft_done` while in `S_IDLE` → ignored; `frames_issued` unchanged and no bank is released.
